// File: rtl/mem_load_sequencer_pkg.sv
// rtl/mem_load_sequencer_pkg.sv - shared types and default sizes for the memory load sequencer
package loader_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      SETTLE = 3'd3,
      DONE   = 3'd4
   } load_state_t;

   localparam int DEF_A_DEPTH       = 16384;
   localparam int DEF_B_DEPTH       = 1152;
   localparam int DEF_A_ADDR_W      = 14;
   localparam int DEF_B_ADDR_W      = 11;
   localparam int DEF_SETTLE_CYCLES = 34;

endpackage

// File: rtl/mem_load_sequencer_wrap_counter.sv
// rtl/mem_load_sequencer_wrap_counter.sv - address counter that wraps at an arbitrary depth
module wrap_counter #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_in,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count,
   output logic             last
);

   localparam logic [WIDTH-1:0] LAST_VAL = WIDTH'(DEPTH - 1);

   assign last = (count == LAST_VAL);

   // Wrap on the terminal value so non-power-of-2 depths never overrun.
   always_ff @(posedge clk) begin
      if (rst_in || clr) begin
         count <= '0;
      end else if (inc) begin
         count <= last ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/mem_load_sequencer.sv
// rtl/mem_load_sequencer.sv - preloads activation/weight SRAMs from valid/ready streams
module mem_load_sequencer
   import loader_pkg::*;
#(
   parameter int A_DEPTH       = DEF_A_DEPTH,
   parameter int B_DEPTH       = DEF_B_DEPTH,
   parameter int A_ADDR_W      = DEF_A_ADDR_W,
   parameter int B_ADDR_W      = DEF_B_ADDR_W,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
   input  logic                clk,
   input  logic                rst_in,
   input  logic                start,
   input  logic                reload_b,
   input  logic                a_valid,
   output logic                a_ready,
   input  logic                b_valid,
   output logic                b_ready,
   output logic [A_ADDR_W-1:0] amem_addr,
   output logic                amem_write_en,
   output logic [B_ADDR_W-1:0] bmem_addr,
   output logic                bmem_write_en,
   output logic                busy,
   output logic                load_done
);

   localparam int SETTLE_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

   load_state_t         state;
   logic [SETTLE_W-1:0] settle_cnt;
   logic                a_last;
   logic                b_last;
   logic                in_idle;

   assign in_idle       = (state == IDLE);
   assign a_ready       = (state == LOAD_A);
   assign b_ready       = (state == LOAD_B);
   assign amem_write_en = a_valid && a_ready;
   assign bmem_write_en = b_valid && b_ready;
   assign busy          = !in_idle;
   assign load_done     = (state == DONE);

   // Clearing in IDLE guarantees a fresh load always starts at address 0.
   wrap_counter #(
      .WIDTH (A_ADDR_W),
      .DEPTH (A_DEPTH)
   ) u_a_addr (
      .clk    (clk),
      .rst_in (rst_in),
      .clr    (in_idle),
      .inc    (amem_write_en),
      .count  (amem_addr),
      .last   (a_last)
   );

   wrap_counter #(
      .WIDTH (B_ADDR_W),
      .DEPTH (B_DEPTH)
   ) u_b_addr (
      .clk    (clk),
      .rst_in (rst_in),
      .clr    (in_idle),
      .inc    (bmem_write_en),
      .count  (bmem_addr),
      .last   (b_last)
   );

   always_ff @(posedge clk) begin
      if (rst_in) begin
         state      <= IDLE;
         settle_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               settle_cnt <= '0;
               if (start) begin
                  state <= LOAD_A;
               end else if (reload_b) begin
                  state <= LOAD_B;
               end
            end
            LOAD_A: begin
               if (amem_write_en && a_last) begin
                  state <= LOAD_B;
               end
            end
            LOAD_B: begin
               if (bmem_write_en && b_last) begin
                  state <= SETTLE;
               end
            end
            SETTLE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  state      <= DONE;
                  settle_cnt <= '0;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
